// File: rtl/const_to_note.sv
// Phase-increment constant to note index decoder.
// Eight-step binary search over the shifted 12-entry base table.
module const_to_note #(
    parameter int CONST_W = 24,
    parameter int NOTE_W  = 8,
    parameter int REF_OCT = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [CONST_W-1:0] constant_in,
    output logic               out_valid,
    output logic [NOTE_W-1:0]  note,
    output logic [CONST_W-1:0] residual,
    output logic               exact,
    output logic               underrange
);

    typedef enum logic {IDLE, SEARCH} state_t;

    localparam logic [7:0] REF = 8'(REF_OCT);

    state_t state_q, state_d;

    logic [CONST_W-1:0] c_q;
    logic [NOTE_W-1:0]  cand_q, cand_d;
    logic [2:0]         b_q;
    logic [NOTE_W-1:0]  note_q;
    logic [CONST_W-1:0] res_q;
    logic               exact_q;
    logic               under_q;
    logic               out_valid_q;

    logic [NOTE_W-1:0]  trial;
    logic [CONST_W-1:0] t_trial;
    logic [CONST_W-1:0] t_cand;
    logic [CONST_W-1:0] t_fin;
    logic               take;
    logic               under_d;
    logic [CONST_W-1:0] res_d;
    logic               exact_d;

    // Note n -> constant: semitone picks the base, octave shifts it.
    function automatic logic [CONST_W-1:0] tbl(input logic [NOTE_W-1:0] n);
        logic [7:0]         o;
        logic [3:0]         s;
        logic [CONST_W-1:0] b;
        o = n / 8'd12;
        s = 4'(n % 8'd12);
        case (s)
            4'd0:    b = CONST_W'(2608);
            4'd1:    b = CONST_W'(2763);
            4'd2:    b = CONST_W'(2927);
            4'd3:    b = CONST_W'(3101);
            4'd4:    b = CONST_W'(3286);
            4'd5:    b = CONST_W'(3481);
            4'd6:    b = CONST_W'(3688);
            4'd7:    b = CONST_W'(3908);
            4'd8:    b = CONST_W'(4140);
            4'd9:    b = CONST_W'(4386);
            4'd10:   b = CONST_W'(4647);
            default: b = CONST_W'(4923);
        endcase
        if (o < REF) tbl = b >> (REF - o);
        else         tbl = b << (o - REF);
    endfunction

    // One search step plus the result that would be committed on the last one.
    always_comb begin
        trial   = cand_q | (NOTE_W'(1) << b_q);
        t_trial = tbl(trial);
        t_cand  = tbl(cand_q);
        take    = (t_trial <= c_q);
        cand_d  = take ? trial : cand_q;
        t_fin   = take ? t_trial : t_cand;
        under_d = (c_q < CONST_W'(2));
        res_d   = under_d ? '0 : c_q - t_fin;
        exact_d = !under_d && (res_d == '0);
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state: accept from idle, return after the bit-0 step.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = SEARCH;
            SEARCH:  if (b_q == 3'd0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake output: ready whenever idle.
    always_comb begin
        in_ready = (state_q == IDLE);
    end

    // Search datapath and held result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            c_q         <= '0;
            cand_q      <= '0;
            b_q         <= '0;
            note_q      <= '0;
            res_q       <= '0;
            exact_q     <= 1'b0;
            under_q     <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        c_q    <= constant_in;
                        cand_q <= '0;
                        b_q    <= 3'd7;
                    end
                end
                SEARCH: begin
                    cand_q <= cand_d;
                    b_q    <= b_q - 3'd1;
                    if (b_q == 3'd0) begin
                        note_q      <= cand_d;
                        under_q     <= under_d;
                        res_q       <= res_d;
                        exact_q     <= exact_d;
                        out_valid_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_valid  = out_valid_q;
    assign note       = note_q;
    assign residual   = res_q;
    assign exact      = exact_q;
    assign underrange = under_q;

endmodule

// File: doc/const_to_note.md
Name: const_to_note

Overview:
Inverse of the synth engine's note-to-phase-increment constant map. Takes a 24-bit oscillator phase-increment constant and returns the 8-bit note index whose table constant is the largest not exceeding it, plus a residual and flags. Uses an 8-step sequential binary search. Sits beside the oscillator constant path and serves pitch readback, glide/pitch-bend quantisation and the tuning display.

Parameters:
CONST_W, 24, width of phase-increment constant (fixed; the table is sized for it)
NOTE_W, 8, width of note index (fixed; 256 entries)
REF_OCT, 10, octave whose constants equal the base table unshifted

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
in_valid  in  1  constant_in is valid
in_ready  out  1  block is idle and can accept
constant_in  in  24  phase-increment constant to decode
out_valid  out  1  one-cycle pulse: result outputs updated
note  out  8  decoded note index 0..255
residual  out  24  constant minus table(note)
exact  out  1  residual == 0 and not underrange
underrange  out  1  constant < table(0)

Behaviour:
- Table definition, for n in 0..255:
  - o = n/12, s = n%12
  - base[s] = {2608,2763,2927,3101,3286,3481,3688,3908,4140,4386,4647,4923}
  - table(n) = base[s] >> (10-o) when o<10; base[s] << (o-10) otherwise. Shift right truncates.
  - Max is table(255) = 3101<<11 = 6350848, which fits 24 bits.
  - table() is monotonic non-decreasing, with duplicates at low n.
- Result: note = largest n with table(n) <= C; ties resolve to the highest index.
- States: IDLE, SEARCH (3-bit bit counter b).
- Reset (async): state=IDLE, C register=0, candidate=0, note=0, residual=0, exact=0, underrange=0, out_valid=0.
- in_ready = 1 exactly when state==IDLE, including immediately after reset deasserts.
- Accept on a clock edge with in_valid & in_ready:
  - latch C = constant_in
  - candidate=0, b=7
  - go to SEARCH
  - constant_in is ignored thereafter until the next accept.
- SEARCH, each edge:
  - trial = candidate | (1<<b)
  - if table(trial) <= C, candidate = trial
  - decrement b
  - table(trial) is evaluated combinationally within the cycle (12-entry mux, /12, barrel shift); no multicycle paths.
- After the b=0 step (the 8th SEARCH edge):
  - note <= final candidate
  - underrange <= (C < 2)
  - residual <= underrange ? 0 : C - table(final)
  - exact <= !underrange && residual==0
  - out_valid <= 1 for exactly one cycle
  - state <= IDLE
- Latency: accept at edge k; results and out_valid appear after edge k+8. Earliest next accept is edge k+9, so back-to-back throughput is 1 per 9 cycles.
- note, residual, exact and underrange hold their values until the next result. out_valid is 0 otherwise.
- in_valid during SEARCH: ignored, no queuing. The upstream block must hold the request until it sees in_ready.
- Out-of-table C (C > table(255)): note=255, residual = C - 6350848, no overflow flag.
- Reset mid-SEARCH: search aborts immediately, outputs clear, no out_valid pulse.
- Arithmetic: residual is an unsigned 24-bit subtract; it never goes negative by construction.

Test Plan:
- After reset, drive C=4140 -> out_valid 8 edges after accept; note=128, residual=0, exact=1, underrange=0.
- C=4139 -> note=127, residual=231, exact=0. Then C=3481 back-to-back (accept at k+9) -> note=125, exact=1.
- C=0 -> note=0, residual=0, underrange=1, exact=0. C=2 -> note=2 (highest duplicate), exact=1, underrange=0.
- C=0xFFFFFF -> note=255, residual=10426367. C=6350848 -> note=255, exact=1.
- Hold in_valid high continuously while changing constant_in every cycle -> in_ready low for 8 cycles. Only constants sampled at accept edges are decoded, and exactly one out_valid pulse occurs per accept.
- Assert reset 4 cycles into a search -> all outputs 0 asynchronously, no out_valid. After release, in_ready=1 and a fresh C=4923 decodes to note=131, exact=1.
